// File: rtl/fir_stream_adapter_pkg.sv
// ---------------------------------------------------------------------------
// fir_stream_adapter_pkg
// Shared defaults for the folded serial-MAC FIR and its stream adapter, the
// ceiling-log2 helper used to size counters and pointers, and the capture
// action encoding used by the adapter's output stage.
// ---------------------------------------------------------------------------
package fir_stream_adapter_pkg;

   localparam int WIDTH_DATA_DEF = 8;
   localparam int FRAME_LEN_DEF  = 16;
   localparam int RESULT_LAT_DEF = 2;
   localparam int FIFO_DEPTH_DEF = 4;

   // Number of bits needed to index 'value' distinct items.
   function automatic int log2_ceil(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // What the output stage does on a launch edge.
   typedef enum logic [1:0] {
      CAP_NONE = 2'd0,   // no real sample retires this frame
      CAP_LOAD = 2'd1,   // load fir_dout into the output register
      CAP_DROP = 2'd2    // consumer still busy: result is dropped
   } cap_action_e;

endpackage

// File: rtl/fir_stream_adapter_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and first-word fall-through
// read data.
//   clk, rst  : clock, synchronous active-high reset (control state only)
//   push, din : write din at the tail (ignored when full)
//   pop, dout : dout is the head entry; pop removes it (ignored when empty)
//   full, empty, count : occupancy status, count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo
   import fir_stream_adapter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [log2_ceil(DEPTH):0]    count
);

   localparam int PTR_W = log2_ceil(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   // full is taken from the registered count, so a pop in the same cycle
   // never opens room for a push.
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_stream_adapter.sv
// ---------------------------------------------------------------------------
// fir_stream_adapter
// Stream front/back end for the folded serial-MAC FIR. Buffers input samples,
// launches one per FRAME_LEN-clock frame onto the FIR with a frame strobe, and
// returns each real sample's FIR result on an output stream.
//   clk, rst           : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : input sample stream (s_ready = FIFO not full)
//   fir_din, fir_strobe    : sample to FIR (held a whole frame), frame pulse
//   fir_dout               : FIR result, valid RESULT_LAT frames after launch
//   m_data/m_valid/m_ready : result stream
//   underrun : sticky, a frame launched with nothing queued
//   overrun  : sticky, a result was dropped while m_valid was pending
// ---------------------------------------------------------------------------
module fir_stream_adapter
   import fir_stream_adapter_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_DATA_DEF,
   parameter int FRAME_LEN  = FRAME_LEN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int RESULT_LAT = RESULT_LAT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH_DATA-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [WIDTH_DATA-1:0] fir_din,
   output logic                  fir_strobe,
   input  logic [WIDTH_DATA-1:0] fir_dout,
   output logic [WIDTH_DATA-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  underrun,
   output logic                  overrun
);

   localparam int CNT_W   = log2_ceil(FRAME_LEN);
   localparam int COUNT_W = log2_ceil(FIFO_DEPTH) + 1;

   logic [CNT_W-1:0]      cnt;
   logic                  launch;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [WIDTH_DATA-1:0] fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   // Occupancy is not needed here; full/empty carry all the control.
   logic [COUNT_W-1:0]    occ_unused;

   // One bit per launched frame still in the FIR: 1 = real sample.
   logic [RESULT_LAT-1:0] tag_sr;
   logic [RESULT_LAT:0]   tag_next;
   cap_action_e           cap_action;

   assign launch    = (cnt == CNT_W'(FRAME_LEN - 1));
   assign s_ready   = !fifo_full;
   assign fifo_push = s_valid && !fifo_full;
   assign fifo_pop  = launch && !fifo_empty;
   // One bit wider than the register so RESULT_LAT=1 needs no special case.
   assign tag_next  = {tag_sr, !fifo_empty};

   sync_fifo #(
      .WIDTH (WIDTH_DATA),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ_unused)
   );

   // The tag leaving the shift register on a launch edge belongs to the
   // sample launched RESULT_LAT frames earlier, whose result is on fir_dout.
   always_comb begin
      cap_action = CAP_NONE;
      if (launch && tag_sr[RESULT_LAT-1]) begin
         if (m_valid && !m_ready) cap_action = CAP_DROP;
         else                     cap_action = CAP_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         fir_din    <= '0;
         fir_strobe <= 1'b0;
         tag_sr     <= '0;
         m_data     <= '0;
         m_valid    <= 1'b0;
         underrun   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         cnt        <= launch ? '0 : cnt + 1'b1;
         fir_strobe <= launch;

         // Launch stage: next sample (or zero filler) onto the FIR input.
         if (launch) begin
            fir_din <= fifo_empty ? '0 : fifo_dout;
            tag_sr  <= tag_next[RESULT_LAT-1:0];
            if (fifo_empty) underrun <= 1'b1;
         end

         // Capture stage: retire the result of the tagged frame.
         case (cap_action)
            CAP_LOAD: begin
               m_data  <= fir_dout;
               m_valid <= 1'b1;
            end
            CAP_DROP: overrun <= 1'b1;
            default:  if (m_ready) m_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_stream_adapter.sv
module tb_fir_stream_adapter;

   logic       clk;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] fir_din;
   logic       fir_strobe;
   logic [7:0] fir_dout;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       underrun;
   logic       overrun;

   fir_stream_adapter #(
      .WIDTH_DATA (8),
      .FRAME_LEN  (16),
      .FIFO_DEPTH (4),
      .RESULT_LAT (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .fir_din    (fir_din),
      .fir_strobe (fir_strobe),
      .fir_dout   (fir_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .underrun   (underrun),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIR model: result = launched sample + 1, two frames after launch.
   logic [7:0] hist0 = 8'h00;
   logic [7:0] hist1 = 8'h00;
   always @(posedge clk) begin
      if (fir_strobe) begin
         hist1 <= hist0;
         hist0 <= fir_din;
      end
   end
   assign fir_dout = hist1 + 8'd1;

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [8];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         collect_en = 1'b0;
   logic [7:0] outs [16];
   int         out_n = 0;
   int         acc_edge [5];
   int         acc_n;
   logic [7:0] push_vals [5];
   logic       pre;
   int         push_edge [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (collect_en && m_valid && out_n < 16) begin
         outs[out_n] = m_data;
         out_n++;
      end
   endtask

   task automatic run_to(input int e);
      while (cyc < e) tick();
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Present one sample so that it is accepted at edge e.
   task automatic push_at(input int e, input logic [7:0] d);
      run_to(e - 1);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[i].din = 8'h30 + 8'(i * 7);
         vecs[i].exp = 8'h31 + 8'(i * 7);
      end
      push_edge = '{1, 2, 16, 32, 48, 64, 80, 96};
      push_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;

      // ---- reset state, idle frame timing, underrun ----
      reset_dut();
      rst = 1'b1;
      tick();
      check("rst_s_ready", s_ready, 1);
      check("rst_strobe", fir_strobe, 0);
      check("rst_fir_din", fir_din, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_underrun", underrun, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      cyc = 0;
      for (int k = 0; k < 48; k++) begin
         tick();
         check("idle_strobe", fir_strobe, (cyc % 16 == 0) ? 1 : 0);
         if (cyc == 15) check("idle_underrun_pre", underrun, 0);
         if (cyc == 16) check("idle_underrun_post", underrun, 1);
      end
      check("idle_m_valid", m_valid, 0);
      check("idle_fir_din", fir_din, 0);

      // ---- back-to-back pushes, FIFO fills, launch order ----
      reset_dut();
      acc_n   = 0;
      s_valid = 1'b1;
      s_data  = push_vals[0];
      for (int k = 0; k < 50; k++) begin
         pre = s_valid && s_ready;
         tick();
         if (pre) begin
            acc_edge[acc_n] = cyc;
            acc_n++;
            if (acc_n == 5) s_valid = 1'b0;
            else            s_data  = push_vals[acc_n];
         end
         if (cyc == 4)  check("fill_s_ready_low", s_ready, 0);
         if (cyc == 15) check("fill_s_ready_still_low", s_ready, 0);
         if (cyc == 16) check("fill_din_f1", fir_din, 8'h11);
         if (cyc == 24) check("fill_din_midframe", fir_din, 8'h11);
         if (cyc == 32) check("fill_din_f2", fir_din, 8'h22);
         if (cyc == 48) check("fill_din_f3", fir_din, 8'h33);
      end
      check("fill_accepted", acc_n, 5);
      check("fill_edge_4th", acc_edge[3], 4);
      check("fill_edge_5th", acc_edge[4], 17);

      // ---- launch-to-result latency ----
      reset_dut();
      m_ready = 1'b0;
      push_at(1, 8'h10);
      run_to(16);
      check("lat_launch_din", fir_din, 8'h10);
      run_to(47);
      check("lat_m_valid_early", m_valid, 0);
      run_to(48);
      check("lat_m_valid", m_valid, 1);
      check("lat_m_data", m_data, 8'h11);

      // ---- overrun: consumer stalled with two results ----
      reset_dut();
      m_ready = 1'b0;
      push_at(1, 8'hA0);
      push_at(2, 8'hB0);
      run_to(48);
      check("ovr_first_valid", m_valid, 1);
      check("ovr_first_data", m_data, 8'hA1);
      check("ovr_flag_pre", overrun, 0);
      run_to(63);
      check("ovr_flag_before_edge", overrun, 0);
      run_to(64);
      check("ovr_flag", overrun, 1);
      check("ovr_data_kept", m_data, 8'hA1);
      check("ovr_valid_kept", m_valid, 1);
      m_ready = 1'b1;
      tick();
      check("ovr_drain", m_valid, 0);
      check("ovr_sticky", overrun, 1);

      // ---- push+pop at count 2, order across pointer wrap ----
      reset_dut();
      m_ready    = 1'b1;
      out_n      = 0;
      collect_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_at(push_edge[i], vecs[i].din);
         if (i >= 2) check("wrap_count", dut.u_fifo.count, 2);
      end
      run_to(170);
      collect_en = 1'b0;
      check("wrap_n_results", out_n, 8);
      for (int i = 0; i < 8; i++) check("wrap_result", outs[i], vecs[i].exp);

      // ---- reset mid-frame with samples queued ----
      reset_dut();
      m_ready = 1'b0;
      push_at(1, 8'hC0);
      push_at(2, 8'hC1);
      run_to(64);
      check("mid_pre_overrun", overrun, 1);
      check("mid_pre_underrun", underrun, 1);
      push_at(66, 8'hD0);
      push_at(67, 8'hD1);
      push_at(68, 8'hD2);
      check("mid_pre_count", dut.u_fifo.count, 3);
      run_to(71);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
      check("mid_count", dut.u_fifo.count, 0);
      check("mid_s_ready", s_ready, 1);
      check("mid_m_valid", m_valid, 0);
      check("mid_underrun", underrun, 0);
      check("mid_overrun", overrun, 0);
      for (int k = 0; k < 16; k++) begin
         tick();
         check("mid_strobe", fir_strobe, (cyc == 16) ? 1 : 0);
      end
      check("mid_din_discarded", fir_din, 0);
      check("mid_underrun_again", underrun, 1);
      run_to(52);
      check("mid_no_ghost_result", m_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_stream_adapter.md
# fir_stream_adapter

Streaming front/back end for the folded serial-MAC FIR. Accepts samples on a valid/ready input stream, buffers them in a small FIFO, and launches exactly one sample per filter frame (FRAME_LEN clocks) onto the FIR input. It then captures the FIR output for each launched real sample and presents it on a valid/ready output stream. It sits between the host datapath and the FIR, on the same clock, and supplies the frame strobe the FIR's sample-rate registers expect.

## Interface
- WIDTH_DATA, 8, sample width for both input and output streams.
- FRAME_LEN, 16, clocks per sample frame; equals the FIR's N_TAPS; must be ≥ 4.
- FIFO_DEPTH, 4, input FIFO entries; power of two.
- RESULT_LAT, 2, frames between launching a sample and its result being valid on fir_dout; ≥ 1.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  WIDTH_DATA  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  high when the FIFO is not full.
- fir_din  out  WIDTH_DATA  registered sample to the FIR.
- fir_strobe  out  1  one-cycle frame-start pulse to the FIR.
- fir_dout  in  WIDTH_DATA  FIR result.
- m_data  out  WIDTH_DATA  captured result.
- m_valid  out  1  result pending.
- m_ready  in  1  consumer accepts the result.
- underrun  out  1  sticky; a frame launched with the FIFO empty.
- overrun  out  1  sticky; a result was dropped because m_valid was still pending.

## Operation
- Frame counter cnt runs 0..FRAME_LEN-1 and wraps. The launch edge is the rising edge where cnt==FRAME_LEN-1.
- Push: when s_valid && s_ready, s_data is written at the FIFO tail. s_ready = !full is combinational from registered occupancy. A pop in the same cycle does not make room for a push when the FIFO is full.
- Launch edge, FIFO non-empty: pop the head into fir_din and shift tag=1 into a RESULT_LAT-bit tag shift register.
- Launch edge, FIFO empty: load fir_din=0, shift in tag=0, and set underrun.
- Capture: on the launch edge, the tag bit shifted out determines the action.
  - Tag bit = 1 and m_valid is clear (or m_ready is high that cycle): m_data ← fir_dout, m_valid ← 1.
  - Tag bit = 1 and m_valid is high with m_ready low: keep the old m_data and set overrun.
  - Tag bit = 0: no capture.
- m_valid clears on m_ready whenever no new capture happens in the same cycle.
- Occupancy count is 0..FIFO_DEPTH (LOG2(FIFO_DEPTH)+1 bits). Read/write pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave the count unchanged.
- Sticky flags clear only on rst.

## Timing
- Reset values:
  - cnt=0; FIFO empty (s_ready=1).
  - fir_din=0, fir_strobe=0.
  - tag register all zero.
  - m_data=0, m_valid=0, underrun=0, overrun=0.
- Reset mid-operation discards FIFO contents and all pending tags. The first launch edge is the FRAME_LEN-th clock after rst deasserts.
- fir_strobe is registered: high for exactly the one cycle following each launch edge (cnt==0). fir_din is stable for the full frame.
- Input-to-FIR latency, FIFO empty and idle: a sample pushed at edge t is launched at the next launch edge strictly after t.
- Launch-to-result latency: exactly RESULT_LAT frames (RESULT_LAT×FRAME_LEN clocks). m_valid rises one cycle after that launch edge.
- Throughput: one sample per FRAME_LEN clocks. Sustained input faster than this fills the FIFO and deasserts s_ready.

## Structure
- The shared FIR package holds WIDTH_DATA, FRAME_LEN, and RESULT_LAT defaults, and the log2 helper used for counter and pointer widths.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). The frame counter, tag register, and output stage live in the top.
- The frame counter is a local counter; it is not shared with the FIR's internal counters.

## Test plan
(defaults: FRAME_LEN=16, RESULT_LAT=2)
- Reset release, no input → fir_strobe first at cycle 16 and every 16 cycles thereafter. underrun=1 after the first launch; m_valid stays 0; fir_din=0.
- Push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back from reset → s_ready drops after 4 accepted samples. 0x55 is accepted once 0x11 is popped at the first launch edge. fir_din shows 0x11, 0x22, 0x33 on successive frames.
- FIR model returns fir_dout = launched sample + 1 after 2 frames; push 0x10 → m_data=0x11, m_valid=1, exactly 32 clocks after 0x10's launch edge.
- Hold m_ready=0 with two real samples in flight → first result retained, overrun=1 at the second capture edge, m_data unchanged.
- Simultaneous push and pop with the FIFO holding 2 → count stays 2, order preserved across pointer wrap (push 8 samples total, outputs in order).
- Assert rst for 1 cycle mid-frame with 3 queued → FIFO empty, m_valid=0, flags clear; next fir_strobe 16 cycles after release.
